// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect Four game controller.
// Keycode values follow the keyboard scan codes used by the keycode source.
package connect4_pkg;

  localparam int NCOLS_DEF       = 7;
  localparam int NROWS_DEF       = 6;
  localparam int ACK_TIMEOUT_DEF = 4;
  localparam int WIN_LATENCY_DEF = 1;

  localparam logic [7:0] KEY_NONE     = 8'h00;
  localparam logic [7:0] KEY_COL0     = 8'h1E;  // '1' -> column 0
  localparam logic [7:0] KEY_COL_LAST = 8'h24;  // '7' -> column 6
  localparam logic [7:0] KEY_NEWGAME  = 8'h28;  // Enter

  typedef enum logic {
    RED   = 1'b0,
    BLACK = 1'b1
  } player_t;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    RED_W   = 2'b01,
    BLACK_W = 2'b10,
    DRAW    = 2'b11
  } winner_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_SETTLE,
    ST_CHECK,
    ST_GAME_OVER
  } seq_state_t;

  // Winner code naming the given player.
  function automatic winner_t win_code(input player_t p);
    return (p == BLACK) ? BLACK_W : RED_W;
  endfunction

  // The player who is not p.
  function automatic player_t opponent(input player_t p);
    return (p == BLACK) ? RED : BLACK;
  endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Signal bundle between the turn sequencer and its surroundings: keycode source,
// per-column piece-stack blocks, win detector and status consumers.
interface turn_sequencer_if
  import connect4_pkg::*;
#(
  parameter int NCOLS = NCOLS_DEF
);

  logic [7:0]       keycode;
  logic [NCOLS-1:0] col_req;
  logic             col_color;
  logic [NCOLS-1:0] col_ack;
  logic [NCOLS-1:0] col_full;
  logic             win_red;
  logic             win_black;
  logic             turn_black;
  logic [5:0]       move_count;
  logic             invalid_move;
  logic             game_over;
  logic [1:0]       winner;

  // The sequencer side.
  modport master (
    input  keycode,
    input  col_ack,
    input  col_full,
    input  win_red,
    input  win_black,
    output col_req,
    output col_color,
    output turn_black,
    output move_count,
    output invalid_move,
    output game_over,
    output winner
  );

  // Everything around the sequencer: keyboard, columns, win detector, display.
  modport slave (
    output keycode,
    output col_ack,
    output col_full,
    output win_red,
    output win_black,
    input  col_req,
    input  col_color,
    input  turn_black,
    input  move_count,
    input  invalid_move,
    input  game_over,
    input  winner
  );

endinterface

// File: rtl/key_strobe.sv
// Turns the raw keycode level into single-cycle press strobes. A strobe fires
// only on the transition from "no key" to a key, so a held key never repeats.
// Strobes are registered, giving one cycle of latency into the sequencer.
module key_strobe
  import connect4_pkg::*;
#(
  parameter int NCOLS = NCOLS_DEF,
  parameter int CW    = 3
) (
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic [7:0]    keycode,
  output logic          col_strobe,
  output logic [CW-1:0] col_idx,
  output logic          newgame_strobe
);

  logic [7:0] prev_key;
  logic       press;
  logic [7:0] key_off;
  logic       is_col;

  // Edge detect and column decode; keys mapping at or past NCOLS are not columns.
  always_comb begin
    press   = (prev_key == KEY_NONE) && (keycode != KEY_NONE);
    key_off = keycode - KEY_COL0;
    is_col  = (keycode >= KEY_COL0) && (keycode <= KEY_COL_LAST) &&
              (key_off < 8'(NCOLS));
  end

  // prev_key tracks the keycode every cycle regardless of sequencer state.
  // NOTE: registers are written with <= so every flop samples pre-edge values;
  // a blocking = here would let prev_key update before press is evaluated.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      prev_key       <= KEY_NONE;
      col_strobe     <= 1'b0;
      col_idx        <= '0;
      newgame_strobe <= 1'b0;
    end else begin
      prev_key       <= keycode;
      col_strobe     <= press && is_col;
      col_idx        <= key_off[CW-1:0];
      newgame_strobe <= press && (keycode == KEY_NEWGAME);
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Game-level controller for the Connect Four board. Converts key presses into
// single drop requests to the column blocks, alternates red/black turns,
// rejects full columns, abandons moves whose ack never arrives, and watches
// the win detector to declare a win or draw, then holds until a new-game key.
module turn_sequencer
  import connect4_pkg::*;
#(
  parameter int NCOLS       = NCOLS_DEF,
  parameter int NROWS       = NROWS_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int WIN_LATENCY = WIN_LATENCY_DEF
) (
  input logic              frame_clk,
  input logic              Reset,
  turn_sequencer_if.master bus
);

  localparam int CW   = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int TMAX = (ACK_TIMEOUT > WIN_LATENCY) ? ACK_TIMEOUT : WIN_LATENCY;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

  localparam logic [TW-1:0] ACK_LAST    = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] SETTLE_LAST = TW'((WIN_LATENCY > 0) ? WIN_LATENCY - 1 : 0);
  localparam logic [5:0]    MAX_MOVES   = 6'(NCOLS * NROWS);

  // Decoded key presses.
  logic          col_strobe;
  logic [CW-1:0] col_idx;
  logic          newgame_strobe;

  // State and datapath registers with their next values.
  seq_state_t    state,        state_nxt;
  logic [CW-1:0] col_sel,      col_sel_nxt;
  logic [TW-1:0] timer,        timer_nxt;
  logic [5:0]    move_count,   move_count_nxt;
  player_t       turn,         turn_nxt;
  winner_t       winner,       winner_nxt;
  logic          game_over,    game_over_nxt;
  logic          invalid_move, invalid_nxt;

  logic mover_won;
  logic opp_won;

  key_strobe #(
    .NCOLS (NCOLS),
    .CW    (CW)
  ) u_key_strobe (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .keycode        (bus.keycode),
    .col_strobe     (col_strobe),
    .col_idx        (col_idx),
    .newgame_strobe (newgame_strobe)
  );

  // All sequencer state; Reset is asynchronous so a pending request drops at once.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state        <= ST_IDLE;
      col_sel      <= '0;
      timer        <= '0;
      move_count   <= '0;
      turn         <= RED;
      winner       <= NONE;
      game_over    <= 1'b0;
      invalid_move <= 1'b0;
    end else begin
      state        <= state_nxt;
      col_sel      <= col_sel_nxt;
      timer        <= timer_nxt;
      move_count   <= move_count_nxt;
      turn         <= turn_nxt;
      winner       <= winner_nxt;
      game_over    <= game_over_nxt;
      invalid_move <= invalid_nxt;
    end
  end

  // Next-state and datapath update for the move sequence.
  // NOTE: every variable gets its hold value before the case statement, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    col_sel_nxt    = col_sel;
    timer_nxt      = timer;
    move_count_nxt = move_count;
    turn_nxt       = turn;
    winner_nxt     = winner;
    game_over_nxt  = game_over;
    invalid_nxt    = 1'b0;
    mover_won      = (turn == BLACK) ? bus.win_black : bus.win_red;
    opp_won        = (turn == BLACK) ? bus.win_red   : bus.win_black;

    unique case (state)
      ST_IDLE: begin
        if (col_strobe) begin
          if (bus.col_full[col_idx]) begin
            invalid_nxt = 1'b1;
          end else begin
            col_sel_nxt = col_idx;
            state_nxt   = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        timer_nxt = '0;
        state_nxt = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        if (bus.col_ack[col_sel]) begin
          if (move_count < MAX_MOVES) begin
            move_count_nxt = move_count + 6'd1;
          end
          timer_nxt = '0;
          state_nxt = (WIN_LATENCY == 0) ? ST_CHECK : ST_SETTLE;
        end else if (timer == ACK_LAST) begin
          invalid_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      ST_SETTLE: begin
        if (timer == SETTLE_LAST) begin
          state_nxt = ST_CHECK;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      ST_CHECK: begin
        // The mover takes precedence when both flags are up.
        if (mover_won) begin
          winner_nxt    = win_code(turn);
          game_over_nxt = 1'b1;
          state_nxt     = ST_GAME_OVER;
        end else if (opp_won) begin
          winner_nxt    = win_code(opponent(turn));
          game_over_nxt = 1'b1;
          state_nxt     = ST_GAME_OVER;
        end else if (move_count == MAX_MOVES) begin
          winner_nxt    = DRAW;
          game_over_nxt = 1'b1;
          state_nxt     = ST_GAME_OVER;
        end else begin
          turn_nxt  = opponent(turn);
          state_nxt = ST_IDLE;
        end
      end

      ST_GAME_OVER: begin
        if (newgame_strobe) begin
          move_count_nxt = '0;
          winner_nxt     = NONE;
          game_over_nxt  = 1'b0;
          turn_nxt       = RED;
          state_nxt      = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // Drop request is a Moore output of ISSUE, so it lasts exactly one cycle.
  always_comb begin
    bus.col_req   = '0;
    bus.col_color = 1'b0;
    if (state == ST_ISSUE) begin
      bus.col_req   = NCOLS'(1) << col_sel;
      bus.col_color = turn;
    end
  end

  assign bus.turn_black   = turn;
  assign bus.move_count   = move_count;
  assign bus.invalid_move = invalid_move;
  assign bus.game_over    = game_over;
  assign bus.winner       = winner;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer. Expected drop requests go into a
// scoreboard queue when a key is pressed and are popped by a monitor when the
// DUT raises col_req; status outputs are checked at fixed points.
module tb_turn_sequencer;

  typedef struct packed {
    logic [6:0] req;
    logic       color;
  } exp_t;

  logic frame_clk;
  logic Reset;

  turn_sequencer_if #(.NCOLS(7)) bus ();

  turn_sequencer #(
    .NCOLS       (7),
    .NROWS       (6),
    .ACK_TIMEOUT (4),
    .WIN_LATENCY (1)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  int         checks = 0;
  int         errors = 0;
  exp_t       sb_q[$];
  logic       ack_auto;
  logic [6:0] ack_next;
  logic [6:0] ack_force;

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    bus.keycode = k;
    tick();
    bus.keycode = 8'h00;
  endtask

  task automatic expect_req(input logic [6:0] r, input logic c);
    exp_t e;
    e.req   = r;
    e.color = c;
    sb_q.push_back(e);
  endtask

  // Column model: drives acks just after the edge, watches col_req mid-cycle.
  initial begin
    exp_t e;
    bus.col_ack = '0;
    ack_next    = '0;
    forever begin
      @(posedge frame_clk);
      #1;
      bus.col_ack = ack_next | ack_force;
      ack_next    = '0;
      @(negedge frame_clk);
      if (!Reset && bus.col_req != '0) begin
        if (sb_q.size() == 0) begin
          check("col_req_unexpected", 32'(bus.col_req), 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("col_req", 32'(bus.col_req), 32'(e.req));
          check("col_color", 32'(bus.col_color), 32'(e.color));
        end
        if (ack_auto) ack_next = bus.col_req;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset         = 1'b1;
    bus.keycode   = 8'h00;
    bus.col_full  = '0;
    bus.win_red   = 1'b0;
    bus.win_black = 1'b0;
    ack_auto      = 1'b1;
    ack_force     = '0;
    tick();
    tick();

    // Reset state.
    check("rst_col_req", 32'(bus.col_req), 32'h0);
    check("rst_col_color", 32'(bus.col_color), 32'h0);
    check("rst_turn", 32'(bus.turn_black), 32'h0);
    check("rst_moves", 32'(bus.move_count), 32'h0);
    check("rst_invalid", 32'(bus.invalid_move), 32'h0);
    check("rst_game_over", 32'(bus.game_over), 32'h0);
    check("rst_winner", 32'(bus.winner), 32'h0);
    Reset = 1'b0;
    tick();

    // 1: key '1' held 3 frames, acked -> one red drop in column 0.
    expect_req(7'b0000001, 1'b0);
    bus.keycode = 8'h1E;
    repeat (3) tick();
    bus.keycode = 8'h00;
    repeat (4) tick();
    check("t1_moves", 32'(bus.move_count), 32'd1);
    check("t1_turn", 32'(bus.turn_black), 32'h1);
    check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // 2: key '3' held 20 cycles -> exactly one black drop in column 2.
    expect_req(7'b0000100, 1'b1);
    bus.keycode = 8'h20;
    repeat (20) tick();
    bus.keycode = 8'h00;
    repeat (2) tick();
    check("t2_moves", 32'(bus.move_count), 32'd2);
    check("t2_turn", 32'(bus.turn_black), 32'h0);
    check("t2_sb_empty", 32'(sb_q.size()), 32'd0);

    // 3: column 3 full -> one-cycle invalid pulse, no request.
    bus.col_full = 7'b0001000;
    press(8'h21);
    check("t3_invalid_before", 32'(bus.invalid_move), 32'h0);
    tick();
    check("t3_invalid_pulse", 32'(bus.invalid_move), 32'h1);
    tick();
    check("t3_invalid_after", 32'(bus.invalid_move), 32'h0);
    repeat (3) tick();
    check("t3_turn", 32'(bus.turn_black), 32'h0);
    check("t3_moves", 32'(bus.move_count), 32'd2);
    bus.col_full = '0;

    // 4: no ack -> invalid after four cycles of waiting.
    ack_auto = 1'b0;
    expect_req(7'b0000010, 1'b0);
    press(8'h1F);
    repeat (5) tick();
    check("t4_invalid_before", 32'(bus.invalid_move), 32'h0);
    tick();
    check("t4_invalid_pulse", 32'(bus.invalid_move), 32'h1);
    tick();
    check("t4_invalid_after", 32'(bus.invalid_move), 32'h0);
    check("t4_moves", 32'(bus.move_count), 32'd2);
    check("t4_turn", 32'(bus.turn_black), 32'h0);
    check("t4_sb_empty", 32'(sb_q.size()), 32'd0);
    ack_auto = 1'b1;

    // 5: red wins, column keys ignored, Enter restarts.
    bus.win_red = 1'b1;
    expect_req(7'b0000001, 1'b0);
    press(8'h1E);
    repeat (6) tick();
    check("t5_winner", 32'(bus.winner), 32'h1);
    check("t5_game_over", 32'(bus.game_over), 32'h1);
    check("t5_moves", 32'(bus.move_count), 32'd3);
    bus.win_red = 1'b0;
    press(8'h22);
    repeat (6) tick();
    check("t5_hold_game_over", 32'(bus.game_over), 32'h1);
    check("t5_hold_moves", 32'(bus.move_count), 32'd3);
    press(8'h28);
    repeat (2) tick();
    check("t5_new_winner", 32'(bus.winner), 32'h0);
    check("t5_new_game_over", 32'(bus.game_over), 32'h0);
    check("t5_new_moves", 32'(bus.move_count), 32'd0);
    check("t5_new_turn", 32'(bus.turn_black), 32'h0);

    // 5b: both flags up on black's move -> black (the mover) wins.
    expect_req(7'b0000100, 1'b0);
    press(8'h20);
    repeat (6) tick();
    bus.win_red   = 1'b1;
    bus.win_black = 1'b1;
    expect_req(7'b0001000, 1'b1);
    press(8'h21);
    repeat (6) tick();
    check("t5b_winner", 32'(bus.winner), 32'h2);
    check("t5b_game_over", 32'(bus.game_over), 32'h1);
    bus.win_red   = 1'b0;
    bus.win_black = 1'b0;
    press(8'h28);
    repeat (2) tick();

    // 6: 42 acked moves with no win -> draw on the last one.
    for (int i = 0; i < 42; i++) begin
      expect_req(7'(1 << (i % 7)), 1'(i % 2));
      press(8'h1E + 8'(i % 7));
      repeat (6) tick();
      if (i == 40) begin
        check("t6_moves_41", 32'(bus.move_count), 32'd41);
        check("t6_not_over_41", 32'(bus.game_over), 32'h0);
      end
    end
    check("t6_winner", 32'(bus.winner), 32'h3);
    check("t6_game_over", 32'(bus.game_over), 32'h1);
    check("t6_moves", 32'(bus.move_count), 32'd42);
    check("t6_sb_empty", 32'(sb_q.size()), 32'd0);

    // 6b: Reset during WAIT_ACK clears everything at once; late ack is ignored.
    press(8'h28);
    repeat (2) tick();
    expect_req(7'b0000001, 1'b0);
    press(8'h1E);
    repeat (6) tick();
    check("t6b_pre_moves", 32'(bus.move_count), 32'd1);
    ack_auto = 1'b0;
    expect_req(7'b0000010, 1'b1);
    press(8'h1F);
    tick();
    tick();
    Reset = 1'b1;
    #1;
    check("t6b_rst_col_req", 32'(bus.col_req), 32'h0);
    check("t6b_rst_turn", 32'(bus.turn_black), 32'h0);
    check("t6b_rst_moves", 32'(bus.move_count), 32'd0);
    check("t6b_rst_winner", 32'(bus.winner), 32'h0);
    check("t6b_rst_game_over", 32'(bus.game_over), 32'h0);
    tick();
    Reset     = 1'b0;
    ack_force = 7'b0000010;
    tick();
    tick();
    ack_force = '0;
    repeat (4) tick();
    check("t6b_ack_ignored", 32'(bus.move_count), 32'd0);
    check("t6b_turn", 32'(bus.turn_black), 32'h0);
    check("t6b_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
